// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing from a 50 MHz clock with a 25 MHz pixel tick,
// scanning a 320x240 8-bit grayscale frame buffer with 2x2 pixel doubling.
module vga_scanout #(
   parameter int         H_ACTIVE = 640,
   parameter int         H_FP     = 16,
   parameter int         H_SYNC   = 96,
   parameter int         H_BP     = 48,
   parameter int         V_ACTIVE = 480,
   parameter int         V_FP     = 10,
   parameter int         V_SYNC   = 2,
   parameter int         V_BP     = 33,
   parameter int         FB_WIDTH = 320,
   parameter logic [7:0] BORDER   = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  rd_data,
   output logic [16:0] rd_addr,
   output logic        h_sync,
   output logic        v_sync,
   output logic        video_on,
   output logic [7:0]  pixel_out,
   output logic        frame_start,
   output logic        vblank
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_ACT_C  = 10'(H_ACTIVE);
   localparam logic [9:0]  H_LAST_C = 10'(H_TOTAL - 1);
   localparam logic [9:0]  HS_BEG_C = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_END_C = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  V_ACT_C  = 10'(V_ACTIVE);
   localparam logic [9:0]  V_LAST_C = 10'(V_TOTAL - 1);
   localparam logic [9:0]  VS_BEG_C = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [16:0] FB_STEP_C = 17'(FB_WIDTH);

   logic        tick_r;
   logic [9:0]  h_cnt_r;
   logic [9:0]  v_cnt_r;
   logic [16:0] line_base_r;
   logic        en_latched_r;

   logic        active_s;
   logic        h_sync_s;
   logic        v_sync_s;
   logic        h_wrap_s;
   logic        v_wrap_s;

   // Decode of the current counter position: visibility, sync windows, wraps, fetch address.
   always_comb begin
      active_s = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
      h_sync_s = !((h_cnt_r >= HS_BEG_C) && (h_cnt_r < HS_END_C));
      v_sync_s = !((v_cnt_r >= VS_BEG_C) && (v_cnt_r < VS_END_C));
      h_wrap_s = (h_cnt_r == H_LAST_C);
      v_wrap_s = (v_cnt_r == V_LAST_C);
      vblank   = (v_cnt_r >= V_ACT_C);
      // Each frame-buffer pixel covers two columns, so the column offset is h_cnt/2.
      if (active_s) begin
         rd_addr = line_base_r + {8'd0, h_cnt_r[9:1]};
      end else begin
         rd_addr = 17'd0;
      end
   end

   // Pixel tick, raster counters, line base, enable latch and the registered video outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_r       <= 1'b0;
         h_cnt_r      <= 10'd0;
         v_cnt_r      <= 10'd0;
         line_base_r  <= 17'd0;
         en_latched_r <= 1'b0;
         h_sync       <= 1'b1;
         v_sync       <= 1'b1;
         video_on     <= 1'b0;
         pixel_out    <= 8'h00;
         frame_start  <= 1'b0;
      end else begin
         tick_r      <= ~tick_r;
         frame_start <= 1'b0;
         if (tick_r) begin
            // rd_data here is the RAM answer to the address held through this pixel period.
            h_sync   <= h_sync_s;
            v_sync   <= v_sync_s;
            video_on <= active_s;
            if (!active_s) begin
               pixel_out <= 8'h00;
            end else if (en_latched_r) begin
               pixel_out <= rd_data;
            end else begin
               pixel_out <= BORDER;
            end
            if (h_wrap_s) begin
               h_cnt_r <= 10'd0;
               if (v_wrap_s) begin
                  v_cnt_r      <= 10'd0;
                  line_base_r  <= 17'd0;
                  en_latched_r <= enable;
                  frame_start  <= 1'b1;
               end else begin
                  v_cnt_r <= v_cnt_r + 10'd1;
                  // Advance one frame-buffer row after every second visible line.
                  if ((v_cnt_r < V_ACT_C) && v_cnt_r[0]) begin
                     line_base_r <= line_base_r + FB_STEP_C;
                  end else begin
                     line_base_r <= line_base_r;
                  end
               end
            end else begin
               h_cnt_r <= h_cnt_r + 10'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size instance for line timing and addressing, and a
// reduced-geometry instance so whole frames, enable latching and resets fit a short run.
`timescale 1ns/1ps
module tb_vga_scanout;

   typedef struct packed {
      int ha; int hfp; int hsw; int hbp;
      int va; int vfp; int vsw; int vbp;
      int fbw;
   } geo_t;

   localparam geo_t GF = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33, fbw:320};
   localparam geo_t GS = '{ha:16,  hfp:4,  hsw:6,  hbp:6,  va:6,   vfp:2,  vsw:2, vbp:2,  fbw:8};

   logic clk = 1'b0;
   logic reset;
   logic enable;
   logic rec_on = 1'b0;

   logic [7:0]  ram_f, ram_s;
   logic [16:0] rd_addr_f, rd_addr_s;
   logic        h_sync_f, v_sync_f, video_on_f, frame_start_f, vblank_f;
   logic        h_sync_s, v_sync_s, video_on_s, frame_start_s, vblank_s;
   logic [7:0]  pixel_out_f, pixel_out_s;

   int checks = 0;
   int failures = 0;

   always #10 clk = ~clk;

   vga_scanout u_full (
      .clk(clk), .reset(reset), .enable(enable), .rd_data(ram_f), .rd_addr(rd_addr_f),
      .h_sync(h_sync_f), .v_sync(v_sync_f), .video_on(video_on_f), .pixel_out(pixel_out_f),
      .frame_start(frame_start_f), .vblank(vblank_f)
   );

   vga_scanout #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
      .FB_WIDTH(8), .BORDER(8'h00)
   ) u_small (
      .clk(clk), .reset(reset), .enable(enable), .rd_data(ram_s), .rd_addr(rd_addr_s),
      .h_sync(h_sync_s), .v_sync(v_sync_s), .video_on(video_on_s), .pixel_out(pixel_out_s),
      .frame_start(frame_start_s), .vblank(vblank_s)
   );

   // Frame-buffer RAMs: q = addr[7:0], one clk late.
   always @(posedge clk) begin
      ram_f <= rd_addr_f[7:0];
      ram_s <= rd_addr_s[7:0];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int htot(input geo_t g);
      return g.ha + g.hfp + g.hsw + g.hbp;
   endfunction

   function automatic int vtot(input geo_t g);
      return g.va + g.vfp + g.vsw + g.vbp;
   endfunction

   function automatic logic is_active(input geo_t g, input int p);
      int h, v;
      h = p % htot(g);
      v = (p / htot(g)) % vtot(g);
      return (h < g.ha) && (v < g.va);
   endfunction

   // Frame-buffer address of raster pixel p: row v/2, column h/2.
   function automatic int addr_at(input geo_t g, input int p);
      int h, v;
      h = p % htot(g);
      v = (p / htot(g)) % vtot(g);
      if (is_active(g, p)) return (v / 2) * g.fbw + h / 2;
      else return 0;
   endfunction

   // k = clk edges since reset release; pixel p = k/2 is current, p-1 was just registered.
   task automatic model_chk(input string tag, input geo_t g, input logic rst_v, input logic en_v,
                            input logic hs, input logic vs, input logic vid, input logic fs,
                            input logic vb, input logic [16:0] addr, input logic [7:0] pix,
                            inout int k, inout logic en_m, inout logic [7:0] pix_m);
      int ht, vt, q, h, v, p;
      logic e_hs, e_vs, e_vid, e_fs;
      ht = htot(g);
      vt = vtot(g);
      if (!rst_v) begin
         k = 0;
         en_m = 1'b0;
         pix_m = 8'h00;
      end else begin
         k = k + 1;
         if (k % 2 == 0) begin
            q = k / 2 - 1;
            if (is_active(g, q) && en_m) pix_m = 8'(addr_at(g, q));
            else pix_m = 8'h00;
            if ((k / 2) % (ht * vt) == 0) en_m = en_v;
         end
      end
      if (k < 2) begin
         e_hs = 1'b1; e_vs = 1'b1; e_vid = 1'b0;
      end else begin
         q = k / 2 - 1;
         h = q % ht;
         v = (q / ht) % vt;
         e_hs  = !((h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hsw));
         e_vs  = !((v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vsw));
         e_vid = is_active(g, q);
      end
      e_fs = (k >= 2) && (k % 2 == 0) && ((k / 2) % (ht * vt) == 0);
      p = k / 2;
      chk({tag, "h_sync"},      32'(hs),   32'(e_hs));
      chk({tag, "v_sync"},      32'(vs),   32'(e_vs));
      chk({tag, "video_on"},    32'(vid),  32'(e_vid));
      chk({tag, "frame_start"}, 32'(fs),   32'(e_fs));
      chk({tag, "vblank"},      32'(vb),   32'(((p / ht) % vt) >= g.va));
      chk({tag, "rd_addr"},     32'(addr), 32'(addr_at(g, p)));
      chk({tag, "pixel_out"},   32'(pix),  32'(pix_m));
   endtask

   int k_f = 0, k_s = 0;
   logic en_mf = 1'b0, en_ms = 1'b0;
   logic [7:0] pix_mf = 8'h00, pix_ms = 8'h00;

   int hs_fall[$], hs_rise[$], vid_rise[$], vid_fall[$], vs_fall_s[$], vs_rise_s[$], fs_t_s[$];
   int vb_cnt_s = 0;
   logic prev_hs_f = 1'b1, prev_vid_f = 1'b0, prev_vs_s = 1'b1, prev_fs_s = 1'b0;

   // Single compare process: model vs both DUTs every clk, plus edge timestamps for literal checks.
   always @(posedge clk) begin
      logic rst_v, en_v;
      rst_v = reset;
      en_v  = enable;
      #1;
      model_chk("full.", GF, rst_v, en_v, h_sync_f, v_sync_f, video_on_f, frame_start_f,
                vblank_f, rd_addr_f, pixel_out_f, k_f, en_mf, pix_mf);
      model_chk("small.", GS, rst_v, en_v, h_sync_s, v_sync_s, video_on_s, frame_start_s,
                vblank_s, rd_addr_s, pixel_out_s, k_s, en_ms, pix_ms);
      if (rec_on) begin
         if (prev_hs_f && !h_sync_f) hs_fall.push_back(k_f);
         if (!prev_hs_f && h_sync_f) hs_rise.push_back(k_f);
         if (!prev_vid_f && video_on_f) vid_rise.push_back(k_f);
         if (prev_vid_f && !video_on_f) vid_fall.push_back(k_f);
         if (prev_vs_s && !v_sync_s) vs_fall_s.push_back(k_s);
         if (!prev_vs_s && v_sync_s) vs_rise_s.push_back(k_s);
         if (!prev_fs_s && frame_start_s) fs_t_s.push_back(k_s);
         if (k_s >= 768 && k_s < 1536 && vblank_s) vb_cnt_s++;
      end
      prev_hs_f  = h_sync_f;
      prev_vid_f = video_on_f;
      prev_vs_s  = v_sync_s;
      prev_fs_s  = frame_start_s;
   end

   function automatic int qat(input int q[$], input int i);
      if (i < q.size()) return q[i];
      else return -100000;
   endfunction

   int n = 0;

   task automatic wait_to(input int target);
      while (n < target) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int found;
      reset  = 1'b0;
      enable = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_hold_h_sync",   32'(h_sync_f),    32'd1);
      chk("rst_hold_video_on", 32'(video_on_f),  32'd0);
      chk("rst_hold_rd_addr",  32'(rd_addr_f),   32'd0);
      chk("rst_hold_fs",       32'(frame_start_f), 32'd0);
      reset  = 1'b1;
      rec_on = 1'b1;
      n = 0;

      wait_to(350);  chk("s_addr_last_active", 32'(rd_addr_s), 32'd23);
      wait_to(800);  chk("s_pix_frame1_x15",   32'(pixel_out_s), 32'd7);
      wait_to(1278); chk("f_addr_x638",        32'(rd_addr_f), 32'd319);
      wait_to(1728); enable = 1'b0;
      wait_to(2336); chk("s_pix_disabled",     32'(pixel_out_s), 32'd0);
      wait_to(2504); enable = 1'b1;
      wait_to(2592); chk("s_pix_still_border", 32'(pixel_out_s), 32'd0);
      wait_to(3104); chk("s_pix_resumed",      32'(pixel_out_s), 32'd7);
      wait_to(3200); chk("f_addr_line2",       32'(rd_addr_f), 32'd320);
      wait_to(4806); chk("f_addr_line3_x3",    32'(rd_addr_f), 32'd321);
      wait_to(7892);

      rec_on = 1'b0;
      reset  = 1'b0;
      @(negedge clk);
      reset  = 1'b1;
      chk("mid_rst_s_h_sync",   32'(h_sync_s),      32'd1);
      chk("mid_rst_s_v_sync",   32'(v_sync_s),      32'd1);
      chk("mid_rst_s_video_on", 32'(video_on_s),    32'd0);
      chk("mid_rst_s_pixel",    32'(pixel_out_s),   32'd0);
      chk("mid_rst_s_fs",       32'(frame_start_s), 32'd0);
      chk("mid_rst_f_rd_addr",  32'(rd_addr_f),     32'd0);

      found = 0;
      for (int i = 1; i <= 1000 && found == 0; i++) begin
         @(negedge clk);
         if (frame_start_s) found = i;
      end
      chk("s_fs_after_rst", 32'(found), 32'd768);
      chk("s_addr_after_rst_wrap", 32'(rd_addr_s), 32'd0);

      chk("f_hs_period",      32'(qat(hs_fall, 1) - qat(hs_fall, 0)), 32'd1600);
      chk("f_hs_low",         32'(qat(hs_rise, 0) - qat(hs_fall, 0)), 32'd192);
      chk("f_video_on_width", 32'(qat(vid_fall, 0) - qat(vid_rise, 0)), 32'd1280);
      chk("f_vid_to_hs",      32'(qat(hs_fall, 0) - qat(vid_rise, 0)), 32'd1312);
      chk("s_vs_period",      32'(qat(vs_fall_s, 1) - qat(vs_fall_s, 0)), 32'd768);
      chk("s_vs_low",         32'(qat(vs_rise_s, 0) - qat(vs_fall_s, 0)), 32'd128);
      chk("s_fs_first",       32'(qat(fs_t_s, 0)), 32'd768);
      chk("s_fs_period",      32'(qat(fs_t_s, 1) - qat(fs_t_s, 0)), 32'd768);
      chk("s_vblank_clks",    32'(vb_cnt_s), 32'd384);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Downstream consumer of the 320x240 8-bit grayscale frame buffer (VdRam) written by the zoom/resizer stage. It generates 640x480@60 VGA timing from the 50 MHz clock using a 25 MHz pixel tick. It fetches frame-buffer pixels through the RAM read port with incremental 2x2 pixel-doubling addressing, so no multiplier is used. It outputs sync, blank and pixel data aligned to each other, plus frame/vblank status for the controller.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
FB_WIDTH, 320, frame-buffer pixels per row
BORDER, 8'h00, pixel value driven while output is disabled

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-low reset
enable  input  1  image output enable; sampled only at frame boundary
rd_data  input  8  frame-buffer RAM q; valid 1 clk after rd_addr
rd_addr  output  17  frame-buffer RAM read address
h_sync  output  1  horizontal sync, active-low
v_sync  output  1  vertical sync, active-low
video_on  output  1  high during visible area (drives VGA_BLANK_N)
pixel_out  output  8  grayscale pixel, 0 outside visible area
frame_start  output  1  1-clk pulse when counters wrap to (0,0)
vblank  output  1  high while v_cnt >= V_ACTIVE

Behaviour:
- Clock and reset: reset is sampled on the rising edge of clk, active low. On reset: tick=0, h_cnt=0, v_cnt=0, line_base=0, en_latched=0. Outputs: h_sync=1, v_sync=1, video_on=0, pixel_out=0, frame_start=0, rd_addr=0, vblank=0.
- Pixel tick: the tick flop toggles every clk, so it is high on every other clk. The first tick occurs on the 2nd clk after reset release.
- Counters advance only on a tick clk:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = 800.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL = 525, and wraps to 0.
- Visible area: active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Sync windows:
  - h_sync low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - v_sync low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- Addressing:
  - rd_addr = line_base + h_cnt[9:1] when active, else 0. It is combinational from the registered counters and stable for the whole 2-clk pixel period.
  - line_base updates at each line wrap (tick with h_cnt = H_TOTAL-1):
    - if v_cnt = V_TOTAL-1: line_base goes to 0;
    - else if v_cnt < V_ACTIVE and v_cnt[0] = 1: line_base += FB_WIDTH;
    - otherwise: line_base holds.
  - Resulting range: 0..76799. No wrap beyond 76799 is possible.
- Output alignment:
  - h_sync, v_sync, video_on and pixel_out are all registered on tick clks.
  - Each reflects the counter state of the pixel period just ending, so all four share a latency of 1 pixel period (2 clk) from the counters.
  - rd_data is sampled on the tick clk, which is 1 clk after the address was stable.
- Pixel value: pixel_out = rd_data when active and en_latched; BORDER when active and !en_latched; 0 when not active.
- Enable latching: en_latched <= enable only on the tick where the counters wrap to (0,0). Changes mid-frame therefore take effect at the next frame start, so no tearing.
- frame_start: high for exactly the one clk on which the (0,0) wrap is registered. This is at most one pulse per 840000 clk.
- vblank: combinational from v_cnt (v_cnt >= V_ACTIVE).
- Reset mid-operation: every register returns to its reset value on the next edge. The frame restarts at (0,0), but no frame_start pulse is issued for the restart itself.
- Widths:
  - h_cnt and v_cnt are 10 bits; line_base and rd_addr are 17 bits.
  - All comparisons are unsigned.
  - h_cnt[9:1] is zero-extended for the add.

Test Plan:
1. Hold reset low 5 clk with enable=1 -> h_sync=1, v_sync=1, video_on=0, pixel_out=0, rd_addr=0, frame_start=0 on every cycle.
2. Run 2 lines -> h_sync period 1600 clk with low time 192 clk; video_on high 1280 clk per active line; h_sync falls 1312 clk after video_on rises.
3. Run 2 frames -> v_sync period 840000 clk with low time 3200 clk; frame_start pulses exactly once per 840000 clk, 1 clk wide; vblank high 72000 clk per frame.
4. RAM model q = addr[7:0] delayed 1 clk, enable=1 -> line 0: pixels x=0,1 show 0x00, x=638,639 show addr 319 (0x3F). Lines 2 and 3 start at addr 320. Line 479 ends at addr 76799. The next frame restarts at addr 0.
5. Deassert enable at v_cnt=100 -> pixel_out keeps tracking rd_data until the next frame_start, then shows 8'h00 in the visible area. Reassert -> data resumes only after the following frame_start.
6. Pulse reset low 1 clk at h_cnt=300, v_cnt=100 -> next cycle all outputs at reset values. After release, the first frame_start arrives 840000 clk later and addressing restarts at 0.
